// File: rtl/al_commit_pkg.sv
// Shared types for the active-list commit path.
package al_commit_pkg;

    localparam int AL_DEPTH = 128;
    localparam int AL_INDEX = $clog2(AL_DEPTH);

    typedef logic [AL_INDEX-1:0] al_idx_t;
    typedef logic [AL_INDEX:0]   al_cnt_t;

    // One ready-RAM entry: bit0 = ready, bit1 = exception.
    typedef struct packed {
        logic exc;
        logic ready;
    } rb_entry_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } cs_state_t;

endpackage

// File: rtl/al_ready_prefix.sv
// Longest contiguous ready, non-exceptional prefix over a set of lanes.
// Purely combinational; shared with the LSQ retire path.
module al_ready_prefix #(
    parameter int LANES = 4,
    parameter int NW    = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0] lane_vld,
    input  logic [LANES-1:0] lane_ready,
    input  logic [LANES-1:0] lane_exc,
    output logic [LANES-1:0] eligible,
    output logic [NW-1:0]    n_elig,
    output logic             head_exc
);

    logic run;

    // Thermometer mask: a lane qualifies only if every lane below it did.
    always_comb begin
        run      = 1'b1;
        eligible = '0;
        n_elig   = '0;
        for (int k = 0; k < LANES; k++) begin
            run         = run & lane_vld[k] & lane_ready[k] & ~lane_exc[k];
            eligible[k] = run;
            if (run) begin
                n_elig = n_elig + NW'(1);
            end
        end
    end

    // Exception only matters once it is the oldest valid entry.
    assign head_exc = lane_vld[0] & lane_ready[0] & lane_exc[0];

endmodule

// File: rtl/al_commit_sequencer.sv
// Active-list retirement controller: retires the ready prefix at the head,
// clears retired ready bits, and parks on an exceptional head until recovery.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | retiring up to COMMIT_W entries per cycle from the head
// EXC_WAIT | head entry raised an exception; waiting for exception_ack_i
module al_commit_sequencer
    import al_commit_pkg::*;
#(
    parameter int COMMIT_W = 4,
    parameter int DEPTH    = 128,
    parameter int INDEX    = 7,
    parameter int RB_WIDTH = 2,
    parameter int CW       = $clog2(COMMIT_W) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [COMMIT_W*INDEX-1:0]    rd_addr_o,
    input  logic [COMMIT_W*RB_WIDTH-1:0] rd_data_i,
    output logic [COMMIT_W-1:0]          clr_we_o,
    output logic [COMMIT_W*INDEX-1:0]    clr_addr_o,
    output logic [COMMIT_W*RB_WIDTH-1:0] clr_data_o,
    input  logic [CW-1:0]                dispatch_cnt_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output logic [COMMIT_W-1:0]          commit_vld_o,
    output logic [COMMIT_W*INDEX-1:0]    commit_idx_o,
    output logic [INDEX-1:0]             head_o,
    output logic [INDEX-1:0]             tail_o,
    output logic [INDEX:0]               count_o,
    output logic [INDEX:0]               free_o,
    output logic                         exception_o,
    output logic [INDEX-1:0]             exception_idx_o,
    input  logic                         exception_ack_i
);

    localparam logic [0:0] ST_RUN      = 1'(RUN);
    localparam logic [0:0] ST_EXC_WAIT = 1'(EXC_WAIT);

    logic [0:0]                state;
    logic [INDEX-1:0]          head;
    logic [INDEX:0]            count;
    logic                      run_ok;
    logic [COMMIT_W-1:0]       lane_vld;
    logic [COMMIT_W-1:0]       lane_ready;
    logic [COMMIT_W-1:0]       lane_exc;
    logic [COMMIT_W-1:0]       eligible;
    logic [CW-1:0]             n_elig;
    logic                      head_exc;
    logic [COMMIT_W*INDEX-1:0] lane_addr;
    rb_entry_t                 ent;

    // Lane addresses wrap naturally through INDEX-bit truncation; lanes past
    // the occupancy or outside an unstalled RUN cycle are masked off here.
    always_comb begin
        run_ok     = (state == ST_RUN) && !stall_i && !flush_i;
        lane_addr  = '0;
        lane_vld   = '0;
        lane_ready = '0;
        lane_exc   = '0;
        ent        = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            ent = rb_entry_t'(rd_data_i[k*RB_WIDTH +: $bits(rb_entry_t)]);
            lane_addr[k*INDEX +: INDEX] = head + INDEX'(k);
            lane_vld[k]   = run_ok && ((INDEX+1)'(k) < count);
            lane_ready[k] = ent.ready;
            lane_exc[k]   = ent.exc;
        end
    end

    al_ready_prefix #(
        .LANES (COMMIT_W),
        .NW    (CW)
    ) u_prefix (
        .lane_vld   (lane_vld),
        .lane_ready (lane_ready),
        .lane_exc   (lane_exc),
        .eligible   (eligible),
        .n_elig     (n_elig),
        .head_exc   (head_exc)
    );

    // Clears land on the same edge that retires the entry.
    assign rd_addr_o   = lane_addr;
    assign clr_addr_o  = lane_addr;
    assign clr_we_o    = eligible;
    assign clr_data_o  = '0;
    assign head_o      = head;
    assign count_o     = count;
    assign tail_o      = head + count[INDEX-1:0];
    assign free_o      = (INDEX+1)'(DEPTH) - count;
    assign exception_o = (state == ST_EXC_WAIT);

    // Pointer/occupancy update, retirement report and exception handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_RUN;
            head            <= '0;
            count           <= '0;
            commit_vld_o    <= '0;
            commit_idx_o    <= '0;
            exception_idx_o <= '0;
        end else if (flush_i) begin
            state        <= ST_RUN;
            count        <= '0;
            commit_vld_o <= '0;
        end else if (state == ST_RUN) begin
            commit_vld_o <= eligible;
            commit_idx_o <= lane_addr;
            head         <= head + INDEX'(n_elig);
            count        <= count - (INDEX+1)'(n_elig) + (INDEX+1)'(dispatch_cnt_i);
            if (head_exc) begin
                state           <= ST_EXC_WAIT;
                exception_idx_o <= head;
            end
        end else begin
            // Dispatch is ignored while parked; the ack empties the list
            // and leaves head on the faulting entry.
            commit_vld_o <= '0;
            if (exception_ack_i) begin
                count <= '0;
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_al_commit_sequencer.sv
// Bench for al_commit_sequencer: queue-level model of the active list plus
// a ready-RAM array, compared every cycle, with directed literal checks.
module tb_al_commit_sequencer;

    localparam int W   = 4;
    localparam int D   = 128;
    localparam int I   = 7;
    localparam int RBW = 2;
    localparam int CW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [W*I-1:0]   rd_addr_o;
    logic [W*RBW-1:0] rd_data_i;
    logic [W-1:0]     clr_we_o;
    logic [W*I-1:0]   clr_addr_o;
    logic [W*RBW-1:0] clr_data_o;
    logic [CW-1:0]    dispatch_cnt_i;
    logic             stall_i;
    logic             flush_i;
    logic [W-1:0]     commit_vld_o;
    logic [W*I-1:0]   commit_idx_o;
    logic [I-1:0]     head_o;
    logic [I-1:0]     tail_o;
    logic [I:0]       count_o;
    logic [I:0]       free_o;
    logic             exception_o;
    logic [I-1:0]     exception_idx_o;
    logic             exception_ack_i;

    al_commit_sequencer #(
        .COMMIT_W (W),
        .DEPTH    (D),
        .INDEX    (I),
        .RB_WIDTH (RBW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rd_addr_o       (rd_addr_o),
        .rd_data_i       (rd_data_i),
        .clr_we_o        (clr_we_o),
        .clr_addr_o      (clr_addr_o),
        .clr_data_o      (clr_data_o),
        .dispatch_cnt_i  (dispatch_cnt_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .commit_vld_o    (commit_vld_o),
        .commit_idx_o    (commit_idx_o),
        .head_o          (head_o),
        .tail_o          (tail_o),
        .count_o         (count_o),
        .free_o          (free_o),
        .exception_o     (exception_o),
        .exception_idx_o (exception_idx_o),
        .exception_ack_i (exception_ack_i)
    );

    always #5 clk = ~clk;

    // Model state: the list as head/occupancy over a ring, plus the RAM.
    int         m_head, m_count, m_eidx, m_n;
    bit         m_exc_state;
    bit         m_hexc;
    logic [W-1:0] m_cv;
    int         m_cidx [W];
    logic [1:0] mem [D];
    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Retire count from the list rules: walk from the head while entries
    // exist and are ready without exception.
    function automatic void model_comb();
        bit go;
        logic [1:0] e;
        m_n    = 0;
        m_hexc = 0;
        go     = !m_exc_state && !stall_i && !flush_i;
        for (int k = 0; k < W; k++) begin
            if (go && k < m_count) begin
                e = mem[(m_head + k) % D];
                if (e == 2'b01) m_n++;
                else begin
                    if (k == 0 && e == 2'b11) m_hexc = 1;
                    go = 0;
                end
            end else go = 0;
        end
    endfunction

    function automatic void model_update();
        int oh, oc;
        model_comb();
        oh = m_head;
        oc = m_count;
        if (reset) begin
            m_head = 0; m_count = 0; m_exc_state = 0; m_cv = '0; m_eidx = 0;
            for (int k = 0; k < W; k++) m_cidx[k] = 0;
        end else if (flush_i) begin
            m_count = 0; m_exc_state = 0; m_cv = '0;
        end else if (!m_exc_state) begin
            for (int k = 0; k < m_n; k++) mem[(oh + k) % D] = 2'b00;
            for (int k = 0; k < int'(dispatch_cnt_i); k++) mem[(oh + oc + k) % D] = 2'b00;
            m_cv = W'((1 << m_n) - 1);
            for (int k = 0; k < W; k++) m_cidx[k] = (oh + k) % D;
            m_head  = (oh + m_n) % D;
            m_count = oc - m_n + int'(dispatch_cnt_i);
            if (m_hexc) begin
                m_exc_state = 1;
                m_eidx      = oh;
            end
        end else begin
            m_cv = '0;
            if (exception_ack_i) begin
                m_count = 0; m_exc_state = 0;
            end
        end
    endfunction

    function automatic void drive_rd();
        for (int k = 0; k < W; k++) rd_data_i[k*RBW +: RBW] = mem[(m_head + k) % D];
    endfunction

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            model_comb();
            for (int k = 0; k < W; k++) begin
                chk("rd_addr", rd_addr_o[k*I +: I], (m_head + k) % D);
                chk("clr_addr", clr_addr_o[k*I +: I], (m_head + k) % D);
                if (m_cv[k]) chk("commit_idx", commit_idx_o[k*I +: I], m_cidx[k]);
            end
            chk("clr_we", clr_we_o, (1 << m_n) - 1);
            chk("clr_data", clr_data_o, 0);
            chk("head", head_o, m_head);
            chk("tail", tail_o, (m_head + m_count) % D);
            chk("count", count_o, m_count);
            chk("free", free_o, D - m_count);
            chk("exception", exception_o, m_exc_state);
            chk("exception_idx", exception_idx_o, m_eidx);
            chk("commit_vld", commit_vld_o, m_cv);
        end
    end

    // Upstream must never over-allocate.
    always @(posedge clk) begin
        if (!reset && !flush_i && !exception_o)
            assert (int'(dispatch_cnt_i) <= int'(free_o))
            else $error("protocol: dispatch %0d over free %0d", dispatch_cnt_i, free_o);
    end

    task automatic set_in(input int disp, input bit st, input bit fl, input bit ack);
        dispatch_cnt_i  = CW'(disp);
        stall_i         = st;
        flush_i         = fl;
        exception_ack_i = ack;
    endtask

    task automatic cyc();
        drive_rd();
        @(posedge clk);
        model_update();
        #1;
        drive_rd();
    endtask

    task automatic prep();
        drive_rd();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        rd_data_i = '0;
        m_head = 0; m_count = 0; m_exc_state = 0; m_eidx = 0; m_cv = '0;
        for (int k = 0; k < W; k++) m_cidx[k] = 0;
        for (int a = 0; a < D; a++) mem[a] = 2'b00;

        cyc();
        chk_en = 1;
        cyc();
        chk("rst head", head_o, 0);
        chk("rst count", count_o, 0);
        chk("rst free", free_o, 128);
        chk("rst commit_vld", commit_vld_o, 0);
        chk("rst commit_idx", commit_idx_o, 0);
        chk("rst exception", exception_o, 0);
        chk("rst exception_idx", exception_idx_o, 0);
        reset = 1'b0;

        // 1: partial prefix, entry 2 not ready
        set_in(4, 0, 0, 0); cyc();
        set_in(0, 0, 0, 0);
        mem[0] = 2'b01; mem[1] = 2'b01; mem[3] = 2'b01;
        prep();
        chk("t1 clr_we", clr_we_o, 4'b0011);
        cyc();
        chk("t1 commit_vld", commit_vld_o, 4'b0011);
        chk("t1 head", head_o, 2);
        chk("t1 count", count_o, 2);
        chk("t1 idx1", commit_idx_o[1*I +: I], 1);
        mem[2] = 2'b01; cyc();
        chk("t1 drain head", head_o, 4);

        // walk head up to 126
        for (int i = 0; i < 30; i++) begin
            set_in(4, 0, 0, 0); cyc();
            for (int j = 0; j < 4; j++) mem[(m_head + j) % D] = 2'b01;
            set_in(0, 0, 0, 0); cyc();
        end
        set_in(2, 0, 0, 0); cyc();
        mem[124] = 2'b01; mem[125] = 2'b01;
        set_in(0, 0, 0, 0); cyc();
        chk("walk head", head_o, 126);

        // 2: wrap inside one cycle
        set_in(4, 0, 0, 0); cyc();
        mem[126] = 2'b01; mem[127] = 2'b01; mem[0] = 2'b01; mem[1] = 2'b01;
        set_in(0, 0, 0, 0);
        prep();
        chk("t2 addr0", rd_addr_o[0*I +: I], 126);
        chk("t2 addr1", rd_addr_o[1*I +: I], 127);
        chk("t2 addr2", rd_addr_o[2*I +: I], 0);
        chk("t2 addr3", rd_addr_o[3*I +: I], 1);
        cyc();
        chk("t2 commit_vld", commit_vld_o, 4'b1111);
        chk("t2 head", head_o, 2);
        chk("t2 count", count_o, 0);
        chk("t2 idx3", commit_idx_o[3*I +: I], 1);

        // 3: exception at lane 2
        set_in(1, 0, 0, 0); cyc();
        mem[2] = 2'b01;
        set_in(0, 0, 0, 0); cyc();
        set_in(4, 0, 0, 0); cyc();
        mem[3] = 2'b01; mem[4] = 2'b01; mem[5] = 2'b11; mem[6] = 2'b01;
        set_in(0, 0, 0, 0); cyc();
        chk("t3 commit_vld", commit_vld_o, 4'b0011);
        chk("t3 head", head_o, 5);
        cyc();
        chk("t3 exception", exception_o, 1);
        chk("t3 exception_idx", exception_idx_o, 5);
        set_in(1, 0, 0, 0); cyc();
        set_in(0, 0, 0, 0); cyc(); cyc();
        chk("t3 wait count", count_o, 2);
        chk("t3 wait exception", exception_o, 1);
        set_in(0, 0, 0, 1); cyc();
        chk("t3 ack count", count_o, 0);
        chk("t3 ack head", head_o, 5);
        chk("t3 ack tail", tail_o, 5);
        chk("t3 ack exception", exception_o, 0);

        // 4: stale ready bits beyond occupancy
        set_in(2, 0, 0, 0); cyc();
        mem[5] = 2'b01; mem[6] = 2'b01; mem[7] = 2'b01; mem[8] = 2'b01;
        set_in(3, 0, 0, 0);
        prep();
        chk("t4 clr_we", clr_we_o, 4'b0011);
        cyc();
        chk("t4 commit_vld", commit_vld_o, 4'b0011);
        chk("t4 count", count_o, 3);
        chk("t4 head", head_o, 7);

        // 5: flush beats ack and dispatch in EXC_WAIT
        mem[7] = 2'b11;
        set_in(0, 0, 0, 0); cyc();
        chk("t5 exception_idx", exception_idx_o, 7);
        set_in(2, 0, 1, 1); cyc();
        chk("t5 count", count_o, 0);
        chk("t5 exception", exception_o, 0);
        chk("t5 commit_vld", commit_vld_o, 0);

        // flush in RUN with ready entries retires nothing
        set_in(2, 0, 0, 0); cyc();
        mem[7] = 2'b01; mem[8] = 2'b01;
        set_in(0, 0, 1, 0);
        prep();
        chk("flush clr_we", clr_we_o, 0);
        cyc();
        chk("flush count", count_o, 0);
        chk("flush head", head_o, 7);

        // 6: stall holds retirement but still counts dispatch
        set_in(4, 0, 0, 0); cyc();
        for (int j = 7; j < 11; j++) mem[j] = 2'b01;
        set_in(0, 1, 0, 0);
        prep();
        chk("t6 stall clr_we", clr_we_o, 0);
        cyc();
        set_in(1, 1, 0, 0); cyc();
        chk("t6 stall head", head_o, 7);
        chk("t6 stall count", count_o, 5);
        set_in(0, 0, 0, 0);
        prep();
        chk("t6 clr_we", clr_we_o, 4'b1111);
        cyc();
        chk("t6 commit_vld", commit_vld_o, 4'b1111);
        chk("t6 head", head_o, 11);
        chk("t6 count", count_o, 1);
        chk("t6 free", free_o, 127);

        // reset mid-operation, with flush also high
        reset = 1'b1;
        set_in(0, 0, 1, 0); cyc();
        chk("mid rst head", head_o, 0);
        chk("mid rst count", count_o, 0);
        reset = 1'b0;
        set_in(0, 0, 0, 0); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
